// File: rtl/mips32_mem_dump.sv
// Debug dump engine for the MIPS32 data memory. Once the core reports HALTED, it reads a
// word range one word at a time and presents each word on a valid/ready output port.
module mips32_mem_dump #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              halted,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_HALT = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_CAPTURE   = 3'd3;
    localparam logic [2:0] S_PRESENT   = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    // Two extra bits so that base+count cannot wrap before it is compared with the memory size.
    localparam logic [ADDR_W+1:0] MEM_WORDS = {2'b01, {ADDR_W{1'b0}}};

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W+1:0] span_end;

    assign span_end  = {2'b00, base_addr} + {1'b0, count};
    assign mem_rd_en = (state == S_ISSUE);
    assign mem_addr  = cur_addr;
    // busy is low in both the IDLE and the DONE state, so that it falls together with done.
    assign busy      = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            dout       <= '0;
            dout_addr  <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    if (count == '0) begin
                        done <= 1'b1;
                    end else if (span_end > MEM_WORDS) begin
                        err <= 1'b1;
                    end else begin
                        cur_addr  <= base_addr;
                        remaining <= count;
                        state     <= S_WAIT_HALT;
                    end
                end
            end else if (abort) begin
                // Abort wins over a handshake in the same cycle, and no done pulse follows it.
                dout_valid <= 1'b0;
                state      <= S_IDLE;
            end else begin
                case (state)
                    S_WAIT_HALT: begin
                        if (halted) state <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        dout       <= mem_rdata;
                        dout_addr  <= cur_addr;
                        dout_valid <= 1'b1;
                        state      <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        if (dout_ready) begin
                            dout_valid <= 1'b0;
                            if (remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                remaining <= remaining - 1'b1;
                                cur_addr  <= cur_addr + 1'b1;
                                state     <= S_ISSUE;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
